stack_arbiter: RTL and testbench

//   Shares a single 8-bit LIFO stack between two requesters (A, B) using round-robin arbitration.

---
 rtl/stack_arbiter_if.sv | 35 +++
 rtl/stack_arbiter.sv | 92 +++++++++
 tb/tb_stack_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/stack_arbiter_if.sv
// stack_arbiter_if: requester, stack and status signals of the two-port LIFO arbiter
interface stack_arbiter_if #(parameter int DEPTH = 32);
  localparam int OW = $clog2(DEPTH + 1);
  logic          a_push_req;
  logic          a_pop_req;
  logic [7:0]    a_data_in;
  logic          a_ack;
  logic [7:0]    a_data_out;
  logic          a_error;
  logic          b_push_req;
  logic          b_pop_req;
  logic [7:0]    b_data_in;
  logic          b_ack;
  logic [7:0]    b_data_out;
  logic          b_error;
  logic          stack_push;
  logic          stack_pop;
  logic [7:0]    stack_data_in;
  logic [7:0]    stack_data_out;
  logic          stack_error;
  logic          busy;
  logic [OW-1:0] occupancy;
  modport slave (
    input  a_push_req, a_pop_req, a_data_in, b_push_req, b_pop_req, b_data_in,
           stack_data_out, stack_error,
    output a_ack, a_data_out, a_error, b_ack, b_data_out, b_error,
           stack_push, stack_pop, stack_data_in, busy, occupancy
  );
  modport master (
    output a_push_req, a_pop_req, a_data_in, b_push_req, b_pop_req, b_data_in,
           stack_data_out, stack_error,
    input  a_ack, a_data_out, a_error, b_ack, b_data_out, b_error,
           stack_push, stack_pop, stack_data_in, busy, occupancy
  );
endinterface

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin sharing of one LIFO stack between two requesters with overflow/underflow rejection
module stack_arbiter #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 1
) (
  input logic           clk,
  input logic           reset,
  stack_arbiter_if.slave bus
);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t        state, state_n;
  logic          win_b, last_b, push_op, err;
  logic [7:0]    data, a_hold, b_hold;
  logic          a_err_hold, b_err_hold;
  logic [OW-1:0] occ;
  logic [CW-1:0] cnt;
  logic          a_act, b_act, sel_b, req_push, req_pop, illegal, last_cnt;
  logic [7:0]    req_data;
  always_comb begin
    a_act    = bus.a_push_req | bus.a_pop_req;
    b_act    = bus.b_push_req | bus.b_pop_req;
    sel_b    = b_act & (~a_act | ~last_b);
    req_push = sel_b ? bus.b_push_req : bus.a_push_req;
    req_pop  = sel_b ? bus.b_pop_req : bus.a_pop_req;
    req_data = sel_b ? bus.b_data_in : bus.a_data_in;
    illegal  = (req_push & req_pop) | (req_pop & (occ == '0)) | (req_push & (occ == OW'(DEPTH)));
    last_cnt = cnt == CW'(LATENCY - 1);
    state_n  = state == IDLE  ? ((a_act | b_act) ? (illegal ? RESP : ISSUE) : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (last_cnt ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_b     <= 1'b1;
      win_b      <= 1'b0;
      push_op    <= 1'b0;
      err        <= 1'b0;
      data       <= '0;
      occ        <= '0;
      cnt        <= '0;
      a_hold     <= '0;
      b_hold     <= '0;
      a_err_hold <= 1'b0;
      b_err_hold <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && (a_act | b_act)) begin
        win_b   <= sel_b;
        last_b  <= sel_b;
        push_op <= req_push;
        data    <= req_data;
        err     <= illegal;
      end
      if (state == ISSUE) begin
        occ <= push_op ? occ + OW'(1) : occ - OW'(1);
        cnt <= '0;
      end
      if (state == WAIT) begin
        cnt <= cnt + CW'(1);
        if (last_cnt) begin
          err  <= bus.stack_error;
          data <= push_op ? data : bus.stack_data_out;
        end
      end
      if (state == RESP && !win_b) begin
        a_hold     <= data;
        a_err_hold <= err;
      end
      if (state == RESP && win_b) begin
        b_hold     <= data;
        b_err_hold <= err;
      end
    end
  end
  // data_out/error show the live response during the ack cycle, then hold it
  always_comb begin
    bus.a_ack         = state == RESP && !win_b;
    bus.b_ack         = state == RESP && win_b;
    bus.a_data_out    = bus.a_ack ? data : a_hold;
    bus.b_data_out    = bus.b_ack ? data : b_hold;
    bus.a_error       = bus.a_ack ? err : a_err_hold;
    bus.b_error       = bus.b_ack ? err : b_err_hold;
    bus.stack_push    = state == ISSUE && push_op;
    bus.stack_pop     = state == ISSUE && !push_op;
    bus.stack_data_in = bus.stack_push ? data : 8'h00;
    bus.busy          = state != IDLE;
    bus.occupancy     = occ;
  end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: randomized scoreboard bench for stack_arbiter against a transaction-level model
module tb_stack_arbiter;
  localparam int DEPTH = 32;
  typedef struct {
    bit         b;
    bit         err;
    logic [7:0] data;
    bit         chk_data;
    int         cyc;
  } rsp_t;
  typedef struct {
    bit         push;
    logic [7:0] data;
  } stb_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit inj = 1'b0;
  bit inj_en = 1'b0;
  bit ref_last_b = 1'b1;
  logic [7:0] ref_stk[$];
  logic [7:0] mem[$];
  rsp_t rq[$];
  stb_t sq[$];
  always #5 clk = ~clk;
  stack_arbiter_if #(.DEPTH(DEPTH)) bus();
  stack_arbiter #(.DEPTH(DEPTH), .LATENCY(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always @(posedge clk) cyc <= cyc + 1;
  // behavioural stack: result of a strobe is visible one cycle later
  always @(posedge clk) begin
    if (reset) begin
      mem.delete();
      bus.stack_data_out <= 8'h00;
      bus.stack_error    <= 1'b0;
    end else if (bus.stack_push) begin
      mem.push_back(bus.stack_data_in);
      bus.stack_data_out <= bus.stack_data_in;
      bus.stack_error    <= inj;
    end else if (bus.stack_pop) begin
      if (mem.size() > 0) bus.stack_data_out <= mem.pop_back();
      bus.stack_error <= inj;
    end
  end
  always @(negedge clk) begin
    rsp_t r;
    stb_t s;
    bit who;
    logic [7:0] d;
    logic e;
    tests++;
    if ((bus.a_ack && bus.b_ack) || (bus.stack_push && bus.stack_pop)) begin
      fails++;
      $display("FAIL exclusivity: a_ack=%0d b_ack=%0d push=%0d pop=%0d, required at most one of each pair",
               bus.a_ack, bus.b_ack, bus.stack_push, bus.stack_pop);
    end
    if (bus.stack_push || bus.stack_pop) begin
      tests++;
      if (sq.size() == 0) begin
        fails++;
        $display("FAIL strobe: unexpected push=%0d pop=%0d at cycle %0d", bus.stack_push, bus.stack_pop, cyc);
      end else begin
        s = sq.pop_front();
        if (bus.stack_push != s.push || (s.push && bus.stack_data_in != s.data)) begin
          fails++;
          $display("FAIL strobe: got push=%0d data=%02h, expected push=%0d data=%02h",
                   bus.stack_push, bus.stack_data_in, s.push, s.data);
        end
      end
    end
    if (bus.a_ack || bus.b_ack) begin
      tests++;
      who = bus.b_ack;
      d = who ? bus.b_data_out : bus.a_data_out;
      e = who ? bus.b_error : bus.a_error;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL ack: unexpected ack from %s at cycle %0d", who ? "B" : "A", cyc);
      end else begin
        r = rq.pop_front();
        if (who != r.b || e != r.err || cyc != r.cyc || (r.chk_data && d != r.data)) begin
          fails++;
          $display("FAIL ack: got who=%0d err=%0d data=%02h cyc=%0d, expected who=%0d err=%0d data=%02h cyc=%0d",
                   who, e, d, cyc, r.b, r.err, r.data, r.cyc);
        end
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // op encoding: bit0 push, bit1 pop
  function automatic int serve(input bit who, input int op, input logic [7:0] d, input int t);
    rsp_t r;
    stb_t s;
    r.b = who;
    r.chk_data = 1'b0;
    r.data = 8'h00;
    ref_last_b = who;
    if (op == 3 || (op == 2 && ref_stk.size() == 0) || (op == 1 && ref_stk.size() == DEPTH)) begin
      r.err = 1'b1;
      r.cyc = t + 1;
    end else begin
      r.err = inj;
      r.cyc = t + 3;
      r.chk_data = 1'b1;
      s.push = op == 1;
      s.data = d;
      if (op == 1) begin
        ref_stk.push_back(d);
        r.data = d;
      end else begin
        r.data = ref_stk.pop_back();
        s.data = 8'h00;
      end
      sq.push_back(s);
    end
    rq.push_back(r);
    return r.cyc;
  endfunction
  task automatic do_round(input int oa, input int ob, input logic [7:0] da, input logic [7:0] db);
    int t;
    bit done;
    @(negedge clk);
    inj = inj_en && ($urandom_range(0, 7) == 0);
    bus.a_push_req = oa[0];
    bus.a_pop_req  = oa[1];
    bus.a_data_in  = da;
    bus.b_push_req = ob[0];
    bus.b_pop_req  = ob[1];
    bus.b_data_in  = db;
    t = cyc;
    if (oa != 0 && ob != 0) begin
      if (ref_last_b) void'(serve(1'b1, ob, db, serve(1'b0, oa, da, t) + 1));
      else void'(serve(1'b0, oa, da, serve(1'b1, ob, db, t) + 1));
    end else if (oa != 0) void'(serve(1'b0, oa, da, t));
    else if (ob != 0) void'(serve(1'b1, ob, db, t));
    done = oa == 0 && ob == 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (bus.a_ack) {bus.a_push_req, bus.a_pop_req} = 2'b00;
      if (bus.b_ack) {bus.b_push_req, bus.b_pop_req} = 2'b00;
      done = !(bus.a_push_req | bus.a_pop_req | bus.b_push_req | bus.b_pop_req);
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout: requests still pending after 40 cycles, required acks");
      {bus.a_push_req, bus.a_pop_req, bus.b_push_req, bus.b_pop_req} = 4'b0000;
    end
    @(negedge clk);
    chk("occupancy", int'(bus.occupancy), ref_stk.size());
    chk("busy_idle", int'(bus.busy), 0);
  endtask
  function automatic int pick(input int phase);
    int r;
    int pp;
    r = $urandom_range(0, 99);
    pp = phase == 0 ? 85 : phase == 1 ? 15 : 50;
    if (r < 6) return 3;
    if (r < 20) return 0;
    return ($urandom_range(0, 99) < pp) ? 1 : 2;
  endfunction
  initial begin
    bus.a_push_req = 1'b0;
    bus.a_pop_req  = 1'b0;
    bus.a_data_in  = 8'h00;
    bus.b_push_req = 1'b0;
    bus.b_pop_req  = 1'b0;
    bus.b_data_in  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", int'({bus.a_ack, bus.b_ack}), 0);
    chk("rst_data", int'({bus.a_data_out, bus.b_data_out}), 0);
    chk("rst_err", int'({bus.a_error, bus.b_error}), 0);
    chk("rst_strobe", int'({bus.stack_push, bus.stack_pop, bus.stack_data_in}), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_occ", int'(bus.occupancy), 0);
    reset = 1'b0;
    do_round(1, 0, 8'h5A, 8'h00);
    do_round(1, 1, 8'h01, 8'h02);
    do_round(1, 1, 8'h03, 8'h04);
    do_round(2, 0, 8'h00, 8'h00);
    do_round(0, 2, 8'h00, 8'h00);
    do_round(3, 0, 8'h99, 8'h00);
    // abort an accepted push while it waits on the stack
    @(negedge clk);
    bus.a_push_req = 1'b1;
    bus.a_data_in  = 8'h77;
    sq.push_back('{push: 1'b1, data: 8'h77});
    for (int n = 0; n < 10 && !bus.stack_push; n++) @(negedge clk);
    chk("abort_issue", int'(bus.stack_push), 1);
    @(negedge clk);
    reset = 1'b1;
    bus.a_push_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ref_stk.delete();
    ref_last_b = 1'b1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_occ", int'(bus.occupancy), 0);
    chk("abort_ack", int'({bus.a_ack, bus.b_ack}), 0);
    do_round(2, 2, 8'h00, 8'h00);
    do_round(1, 1, 8'hA1, 8'hB1);
    while (ref_stk.size() < DEPTH) do_round(1, 0, 8'($urandom), 8'h00);
    do_round(1, 1, 8'hEE, 8'hFF);
    while (ref_stk.size() > 0) do_round(0, 2, 8'h00, 8'h00);
    do_round(2, 0, 8'h00, 8'h00);
    do_round(1, 0, 8'h11, 8'h00);
    do_round(0, 1, 8'h00, 8'h22);
    do_round(2, 0, 8'h00, 8'h00);
    do_round(0, 2, 8'h00, 8'h00);
    inj_en = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 60; k++)
        do_round(pick(p), pick(p), 8'($urandom), 8'($urandom));
    chk("rsp_queue_empty", rq.size(), 0);
    chk("strobe_queue_empty", sq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
